// File: rtl/seg7_scan2_if.sv
// rtl/seg7_scan2_if.sv - BCD pair in, multiplexed segment/digit-enable bus out
interface seg7_scan2_if;
  logic [3:0] tens;
  logic [3:0] digits;
  logic [6:0] seg;
  logic [1:0] an;

  // master: counter/board side; slave: the scan driver
  modport master (
    output tens,
    output digits,
    input  seg,
    input  an
  );

  modport slave (
    input  tens,
    input  digits,
    output seg,
    output an
  );
endinterface

// File: rtl/seg7_scan2.sv
// rtl/seg7_scan2.sv - two-digit multiplexed 7-segment scan driver with anti-ghost gaps
module seg7_scan2 #(
  parameter int REFRESH_DIV   = 50000,
  parameter int GAP_CYCLES    = 4,
  parameter bit COMMON_ANODE  = 1'b1,
  parameter bit BLANK_LEADING = 1'b1
) (
  input  logic         Clk,
  input  logic         RST,
  seg7_scan2_if.slave  bus
);

  localparam int MAX_LEN = (REFRESH_DIV > GAP_CYCLES) ? REFRESH_DIV : GAP_CYCLES;
  localparam int CW      = $clog2(MAX_LEN);
  localparam logic [CW-1:0] RUN_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYCLES - 1);
  localparam logic [6:0]    SEG_OFF  = COMMON_ANODE ? 7'h7F : 7'h00;
  localparam logic [1:0]    AN_OFF   = COMMON_ANODE ? 2'b11 : 2'b00;

  typedef enum logic [1:0] {
    S_UNITS,
    S_GAP0,
    S_TENS,
    S_GAP1
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [3:0]    sh_t;
  logic [3:0]    sh_u;
  logic [6:0]    seg_q;
  logic [1:0]    an_q;
  logic          cnt_last;
  logic [6:0]    seg_ah;
  logic [1:0]    an_ah;

  function automatic logic [6:0] seg_decode(input logic [3:0] v);
    case (v)
      4'd0:    seg_decode = 7'h3F;
      4'd1:    seg_decode = 7'h06;
      4'd2:    seg_decode = 7'h5B;
      4'd3:    seg_decode = 7'h4F;
      4'd4:    seg_decode = 7'h66;
      4'd5:    seg_decode = 7'h6D;
      4'd6:    seg_decode = 7'h7D;
      4'd7:    seg_decode = 7'h07;
      4'd8:    seg_decode = 7'h7F;
      4'd9:    seg_decode = 7'h6F;
      default: seg_decode = 7'h40;
    endcase
  endfunction

  always_comb begin
    cnt_last = 1'b0;
    if (state == S_UNITS || state == S_TENS) begin
      cnt_last = (cnt == RUN_LAST);
    end else begin
      cnt_last = (cnt == GAP_LAST);
    end
  end

  // Active-high view of what the current state should show; polarity applied at the register
  always_comb begin
    seg_ah = 7'h00;
    an_ah  = 2'b00;
    case (state)
      S_UNITS: begin
        an_ah  = 2'b01;
        seg_ah = seg_decode(sh_u);
      end
      S_TENS: begin
        if (!(BLANK_LEADING && sh_t == 4'd0)) begin
          an_ah  = 2'b10;
          seg_ah = seg_decode(sh_t);
        end
      end
      default: begin
        an_ah  = 2'b00;
        seg_ah = 7'h00;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (RST) begin
      state <= S_GAP1;
      cnt   <= GAP_LAST;
      sh_t  <= 4'd0;
      sh_u  <= 4'd0;
      seg_q <= SEG_OFF;
      an_q  <= AN_OFF;
    end else begin
      seg_q <= COMMON_ANODE ? ~seg_ah : seg_ah;
      an_q  <= COMMON_ANODE ? ~an_ah  : an_ah;
      if (cnt_last) begin
        cnt <= '0;
        case (state)
          S_UNITS: state <= S_GAP0;
          S_GAP0:  state <= S_TENS;
          S_TENS:  state <= S_GAP1;
          S_GAP1: begin
            // Shadows refresh only at frame start so a frame never mixes old and new values
            state <= S_UNITS;
            sh_t  <= bus.tens;
            sh_u  <= bus.digits;
          end
        endcase
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign bus.seg = seg_q;
  assign bus.an  = an_q;

endmodule
